// File: rtl/riscm_pkg.sv
// Shared definitions for the RISC machine: default widths, next-PC source
// encodings and branch condition encodings.
package riscm_pkg;

    localparam int AW_DEF = 9;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        PCSEL_INC = 2'b00,
        PCSEL_REL = 2'b01,
        PCSEL_REG = 2'b10,
        PCSEL_RSV = 2'b11
    } pc_sel_e;

    typedef enum logic [2:0] {
        COND_AL = 3'b000,
        COND_EQ = 3'b001,
        COND_NE = 3'b010,
        COND_LT = 3'b011,
        COND_LE = 3'b100
    } cond_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator: cond/N/V/Z -> taken.
module branch_cond
    import riscm_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       N,
    input  logic       V,
    input  logic       Z,
    output logic       taken
);

    // Encodings 101..111 are never taken.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_EQ: taken = Z;
            COND_NE: taken = ~Z;
            COND_LT: taken = N ^ V;
            COND_LE: taken = (N ^ V) | Z;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_addr_unit.sv
// Program counter, data-address register and RAM address mux for the RISC
// machine; also evaluates branch conditions and exports the link address.
module pc_addr_unit
    import riscm_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reset_pc,
    input  logic          load_pc,
    input  logic [1:0]    pc_sel,
    input  logic [2:0]    cond,
    input  logic [7:0]    im8,
    input  logic          N,
    input  logic          V,
    input  logic          Z,
    input  logic          addr_sel,
    input  logic          load_addr,
    input  logic [DW-1:0] datapath_out,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] pc_link,
    output logic          br_taken
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] addr_q;
    logic          br_q;
    logic          cond_true;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_rel;
    logic [AW-1:0] pc_next;
    logic          br_next;
    logic          unused_dp_bits;

    assign unused_dp_bits = ^datapath_out[DW-1:AW];

    branch_cond u_branch_cond (
        .cond  (cond),
        .N     (N),
        .V     (V),
        .Z     (Z),
        .taken (cond_true)
    );

    // PC already points past the branch, so the offset is applied to pc_q directly.
    assign pc_inc = pc_q + AW'(1);
    assign pc_rel = pc_q + AW'($signed(im8));

    always_comb begin
        pc_next = pc_inc;
        br_next = 1'b0;
        case (pc_sel)
            PCSEL_REL: begin
                if (cond_true) begin
                    pc_next = pc_rel;
                    br_next = 1'b1;
                end
            end
            PCSEL_REG: begin
                pc_next = datapath_out[AW-1:0];
                br_next = 1'b1;
            end
            default: begin
                pc_next = pc_inc;
                br_next = 1'b0;
            end
        endcase
    end

    // reset_pc only matters when accompanied by load_pc.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q   <= '0;
            addr_q <= '0;
            br_q   <= 1'b0;
        end else begin
            if (load_pc) begin
                if (reset_pc) begin
                    pc_q <= '0;
                    br_q <= 1'b0;
                end else begin
                    pc_q <= pc_next;
                    br_q <= br_next;
                end
            end
            if (load_addr) begin
                addr_q <= datapath_out[AW-1:0];
            end
        end
    end

    assign pc       = pc_q;
    assign br_taken = br_q;
    assign mem_addr = addr_sel ? pc_q : addr_q;
    assign pc_link  = {{(DW-AW){1'b0}}, pc_q};

endmodule

// File: tb/tb_pc_addr_unit.sv
// Self-checking bench for pc_addr_unit: directed vector table plus
// hand-written reset, LDR and link-address sequences.
module tb_pc_addr_unit;

    logic        clk;
    logic        reset;
    logic        reset_pc;
    logic        load_pc;
    logic [1:0]  pc_sel;
    logic [2:0]  cond;
    logic [7:0]  im8;
    logic        N, V, Z;
    logic        addr_sel;
    logic        load_addr;
    logic [15:0] datapath_out;
    logic [8:0]  mem_addr;
    logic [8:0]  pc;
    logic [15:0] pc_link;
    logic        br_taken;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [8:0]  start_pc;
        logic        load_pc;
        logic        reset_pc;
        logic [1:0]  pc_sel;
        logic [2:0]  cond;
        logic [7:0]  im8;
        logic [2:0]  nvz;
        logic [15:0] dp;
        logic [8:0]  exp_pc;
        logic        exp_br;
    } vec_t;

    vec_t vecs[$];

    pc_addr_unit #(.AW(9), .DW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .reset_pc     (reset_pc),
        .load_pc      (load_pc),
        .pc_sel       (pc_sel),
        .cond         (cond),
        .im8          (im8),
        .N            (N),
        .V            (V),
        .Z            (Z),
        .addr_sel     (addr_sel),
        .load_addr    (load_addr),
        .datapath_out (datapath_out),
        .mem_addr     (mem_addr),
        .pc           (pc),
        .pc_link      (pc_link),
        .br_taken     (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idle();
        reset_pc     = 1'b0;
        load_pc      = 1'b0;
        pc_sel       = 2'b00;
        cond         = 3'b000;
        im8          = 8'h00;
        {N, V, Z}    = 3'b000;
        load_addr    = 1'b0;
        datapath_out = 16'h0000;
    endtask

    function automatic vec_t mk(input string name, input logic [8:0] start_pc, input logic lp,
                                input logic rp, input logic [1:0] sel, input logic [2:0] c,
                                input logic [7:0] off, input logic [2:0] nvz, input logic [15:0] dp,
                                input logic [8:0] exp_pc, input logic exp_br);
        vec_t v;
        v.name = name; v.start_pc = start_pc; v.load_pc = lp; v.reset_pc = rp;
        v.pc_sel = sel; v.cond = c; v.im8 = off; v.nvz = nvz; v.dp = dp;
        v.exp_pc = exp_pc; v.exp_br = exp_br;
        return v;
    endfunction

    // Each vector first jumps to start_pc via a register load, then applies one cycle.
    task automatic applyStimulus(input vec_t v);
        idle();
        load_pc      = 1'b1;
        pc_sel       = 2'b10;
        datapath_out = {7'b0, v.start_pc};
        tick();
        load_pc      = v.load_pc;
        reset_pc     = v.reset_pc;
        pc_sel       = v.pc_sel;
        cond         = v.cond;
        im8          = v.im8;
        {N, V, Z}    = v.nvz;
        datapath_out = v.dp;
        addr_sel     = 1'b1;
        tick();
        idle();
        checkOutput({v.name, ".pc"}, 16'(pc), 16'(v.exp_pc));
        checkOutput({v.name, ".br_taken"}, 16'(br_taken), 16'(v.exp_br));
        checkOutput({v.name, ".mem_addr"}, 16'(mem_addr), 16'(v.exp_pc));
    endtask

    initial begin
        idle();
        addr_sel = 1'b1;
        reset    = 1'b1;

        // Reset with a load strobe present: state must still clear.
        reset   = 1'b0;
        load_pc = 1'b1;
        tick();
        reset = 1'b1;
        load_pc = 1'b0;
        checkOutput("rst.pc", 16'(pc), 16'h000);
        checkOutput("rst.br_taken", 16'(br_taken), 16'h0);
        checkOutput("rst.pc_link", pc_link, 16'h0000);
        checkOutput("rst.mem_addr_pc", 16'(mem_addr), 16'h000);
        addr_sel = 1'b0;
        #1;
        checkOutput("rst.mem_addr_data", 16'(mem_addr), 16'h000);
        addr_sel = 1'b1;

        for (int i = 0; i < 5; i++) begin
            load_pc = 1'b1;
            tick();
        end
        load_pc = 1'b0;
        checkOutput("inc5.pc", 16'(pc), 16'h005);
        tick();
        checkOutput("hold.pc", 16'(pc), 16'h005);

        // Directed single-cycle vectors: name, start, load_pc, reset_pc, sel, cond, im8, NVZ, dp, exp_pc, exp_br.
        vecs.push_back(mk("wrap",      9'h1FF, 1, 0, 2'b00, 3'b000, 8'h00, 3'b000, 16'h0000, 9'h000, 0));
        vecs.push_back(mk("beq_t",     9'h010, 1, 0, 2'b01, 3'b001, 8'hFC, 3'b001, 16'h0000, 9'h00C, 1));
        vecs.push_back(mk("beq_nt",    9'h010, 1, 0, 2'b01, 3'b001, 8'hFC, 3'b000, 16'h0000, 9'h011, 0));
        vecs.push_back(mk("bx",        9'h020, 1, 0, 2'b10, 3'b000, 8'h00, 3'b000, 16'hF123, 9'h123, 1));
        vecs.push_back(mk("rstpc",     9'h055, 1, 1, 2'b10, 3'b000, 8'h00, 3'b000, 16'h00AA, 9'h000, 0));
        vecs.push_back(mk("rstpc_nol", 9'h055, 0, 1, 2'b00, 3'b000, 8'h00, 3'b000, 16'h0000, 9'h055, 1));
        vecs.push_back(mk("nold",      9'h077, 0, 0, 2'b01, 3'b000, 8'h10, 3'b000, 16'h0000, 9'h077, 1));
        vecs.push_back(mk("sel11",     9'h030, 1, 0, 2'b11, 3'b000, 8'h10, 3'b000, 16'h01EE, 9'h031, 0));
        vecs.push_back(mk("bne_t",     9'h100, 1, 0, 2'b01, 3'b010, 8'h10, 3'b000, 16'h0000, 9'h110, 1));
        vecs.push_back(mk("bne_nt",    9'h100, 1, 0, 2'b01, 3'b010, 8'h10, 3'b001, 16'h0000, 9'h101, 0));
        vecs.push_back(mk("cond101",   9'h040, 1, 0, 2'b01, 3'b101, 8'h05, 3'b111, 16'h0000, 9'h041, 0));
        vecs.push_back(mk("cond111",   9'h040, 1, 0, 2'b01, 3'b111, 8'h05, 3'b000, 16'h0000, 9'h041, 0));
        vecs.push_back(mk("bal_back",  9'h010, 1, 0, 2'b01, 3'b000, 8'h80, 3'b000, 16'h0000, 9'h190, 1));
        vecs.push_back(mk("bal_wrap",  9'h1FE, 1, 0, 2'b01, 3'b000, 8'h7F, 3'b000, 16'h0000, 9'h07D, 1));

        // BLT/BLE over every N,V,Z combination from 0x020 with offset +5.
        for (int k = 0; k < 8; k++) begin
            logic n, v, z;
            {n, v, z} = 3'(k);
            vecs.push_back(mk($sformatf("blt%0d", k), 9'h020, 1, 0, 2'b01, 3'b011, 8'h05, 3'(k),
                              16'h0000, (n != v) ? 9'h025 : 9'h021, n != v));
            vecs.push_back(mk($sformatf("ble%0d", k), 9'h020, 1, 0, 2'b01, 3'b100, 8'h05, 3'(k),
                              16'h0000, ((n != v) || z) ? 9'h025 : 9'h021, (n != v) || z));
        end

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Link address mirrors pc before a BX away from 0x124.
        load_pc = 1'b1; pc_sel = 2'b10; datapath_out = 16'h0124;
        tick();
        idle();
        checkOutput("link.pc_link", pc_link, 16'h0124);
        load_pc = 1'b1; pc_sel = 2'b10; datapath_out = 16'hF123;
        tick();
        idle();
        checkOutput("link.bx_pc", 16'(pc), 16'h123);
        checkOutput("link.bx_br", 16'(br_taken), 16'h1);

        // LDR address phase, plus a simultaneous PC increment.
        load_addr = 1'b1; datapath_out = 16'h0040; load_pc = 1'b1;
        tick();
        idle();
        addr_sel = 1'b0;
        #1;
        checkOutput("ldr.mem_addr_data", 16'(mem_addr), 16'h040);
        checkOutput("ldr.pc_concurrent", 16'(pc), 16'h124);
        addr_sel = 1'b1;
        #1;
        checkOutput("ldr.mem_addr_pc", 16'(mem_addr), 16'h124);
        tick();
        addr_sel = 1'b0;
        #1;
        checkOutput("ldr.addr_hold", 16'(mem_addr), 16'h040);

        // Reset in the middle of an address phase with strobes active.
        reset = 1'b0; load_addr = 1'b1; load_pc = 1'b1; datapath_out = 16'h0099;
        tick();
        reset = 1'b1;
        idle();
        checkOutput("midrst.mem_addr_data", 16'(mem_addr), 16'h000);
        checkOutput("midrst.pc", 16'(pc), 16'h000);
        checkOutput("midrst.br", 16'(br_taken), 16'h0);
        tick();
        checkOutput("midrst.idle_addr", 16'(mem_addr), 16'h000);
        checkOutput("midrst.idle_pc", 16'(pc), 16'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_addr_unit.md
# pc_addr_unit

Program-counter and memory-address stage for the RISC machine, sitting directly downstream of the control FSM. It consumes the FSM's `reset_pc`, `load_pc`, `addr_sel` and `load_addr` strobes and drives the 9-bit RAM address. It holds the PC and the data-address register, and evaluates branch conditions against the N/V/Z status flags. It also supplies the return address for BL/BLX to the datapath write-back mux.

## Interface
Parameters:
- `AW`, 9: address width (PC, data address, RAM address)
- `DW`, 16: datapath word width

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `reset_pc`  in  1  select zero as next PC (FSM strobe)
- `load_pc`  in  1  PC write enable
- `pc_sel`  in  2  next-PC source: 00 PC+1, 01 PC+sx(im8) if condition true, 10 `datapath_out[AW-1:0]`, 11 reserved (treated as 00)
- `cond`  in  3  branch condition from instruction register
- `im8`  in  8  signed branch offset
- `N`, `V`, `Z`  in  1 each  status flags from datapath
- `addr_sel`  in  1  1 selects PC, 0 selects data address onto `mem_addr`
- `load_addr`  in  1  data-address register write enable
- `datapath_out`  in  DW  datapath result (address source, BX target)
- `mem_addr`  out  AW  RAM address
- `pc`  out  AW  current PC
- `pc_link`  out  DW  zero-extended `pc`, for the R7 write on BL/BLX
- `br_taken`  out  1  registered: last PC load was a taken branch or a register jump

## Operation
- Condition evaluation is combinational:
  - 000 always
  - 001 `Z`
  - 010 `!Z`
  - 011 `N^V`
  - 100 `(N^V)|Z`
  - 101–111 never
- Next-PC priority, highest first:
  - `reset` low: all registers cleared.
  - `reset_pc` with `load_pc`: PC ← 0.
  - `load_pc`: PC ← mux(`pc_sel`).
  - Otherwise PC holds.
  - `reset_pc` without `load_pc` has no effect.
- Next-PC arithmetic:
  - PC+1 is modulo 2^AW; 0x1FF+1 wraps to 0x000.
  - Branch target is PC + sx(im8), truncated to AW bits, modulo 2^AW. PC already points past the branch because the FSM's UpdatePC precedes decode.
  - `pc_sel`=01 with a false condition loads PC+1. PC therefore always advances, and `br_taken` ← 0.
  - `pc_sel`=10 loads `datapath_out[AW-1:0]`; upper bits are ignored. `br_taken` ← 1.
- Data address: when `load_addr` is high, data-address register ← `datapath_out[AW-1:0]`; otherwise it holds.
- `mem_addr` = `addr_sel` ? `pc` : data-address register, combinational with no extra latency.
- `pc_link` = {(DW-AW)'b0, `pc`}.
- `br_taken` updates only on cycles with `load_pc` high. It is cleared by reset and by `reset_pc`.

## Timing
- Reset values (`reset` low at a rising edge): `pc`=0, data address=0, `br_taken`=0. Consequently `mem_addr`=0 for either `addr_sel` and `pc_link`=0.
- Registered outputs (`pc`, `br_taken`, data-address register) change one cycle after the enabling strobe is sampled.
- `mem_addr` and the condition result follow their inputs within the same cycle.
- `load_pc` and `load_addr` high in the same cycle: both registers update independently.
- Reset low mid-instruction (e.g. during a LDR address phase): all state is cleared on that edge regardless of strobes. The first cycle after `reset` returns high behaves as idle.
- No handshake: the FSM guarantees operand stability. The block samples inputs only at rising edges.

## Structure
- Shared package `riscm_pkg`:
  - `AW`, `DW` defaults
  - `pc_sel` encodings: PCSEL_INC, PCSEL_REL, PCSEL_REG
  - cond encodings: COND_AL, COND_EQ, COND_NE, COND_LT, COND_LE
- Natural sub-module: `branch_cond`, a purely combinational cond/N/V/Z → taken evaluator, reused by the FSM if needed.
- All registers live in `pc_addr_unit`.

## Test plan
- Reset low one edge with `load_pc`=1, `pc_sel`=00 -> `pc`=0, `mem_addr`=0, `br_taken`=0. Five `load_pc` cycles -> `pc`=5.
- `pc`=0x1FF, `load_pc`, `pc_sel`=00 -> `pc`=0x000 (wrap).
- `pc`=0x010, BEQ (`cond`=001, `im8`=0xFC): Z=1 -> `pc`=0x00C, `br_taken`=1. Repeat with Z=0 -> `pc`=0x011, `br_taken`=0.
- BLT/BLE sweep over all N,V,Z with `im8`=0x05 from `pc`=0x020 -> 0x025 exactly when N≠V (BLT) or N≠V or Z (BLE), else 0x021.
- BX: `datapath_out`=0xF123, `pc_sel`=10, `load_pc` -> `pc`=0x123, `br_taken`=1. `pc_link` reads 0x0124 beforehand when `pc`=0x124.
- LDR path: `load_addr` with `datapath_out`=0x0040, then `addr_sel`=0 -> `mem_addr`=0x040. `addr_sel`=1 -> `mem_addr`=`pc`. Reset mid-sequence -> `mem_addr`=0.
